// File: rtl/pwm_pkg.sv
// pwm_duty_decoder shared definitions:
// FSM states, percent constants and divider latency.
package pwm_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam int PCT_MAX   = 100;
    localparam int PCT_W     = 7;
    localparam int CNT_W_DEF = 16;

    function automatic int div_cycles(input int cnt_w);
        return cnt_w + PCT_W;
    endfunction

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder control and result bundle.
// master drives the waveform, slave is the decoder.
interface pwm_duty_decoder_if
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic [PCT_W-1:0] duty_pct;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;
    logic             overrun;

    modport master (
        output ena, pwm_in,
        input  period, high_time, duty_pct,
        input  meas_valid, stuck_high, stuck_low, overrun
    );

    modport slave (
        input  ena, pwm_in,
        output period, high_time, duty_pct,
        output meas_valid, stuck_high, stuck_low, overrun
    );

endinterface

// File: rtl/pwm_duty_div.sv
// Restoring divider, one quotient bit per cycle.
// Quotient is clamped to PCT_MAX.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   abort,
    input  logic                   start,
    input  logic [CNT_W+PCT_W-1:0] num,
    input  logic [CNT_W-1:0]       den,
    output logic                   busy,
    output logic                   done,
    output logic [PCT_W-1:0]       quot
);
    localparam int NUM_W  = CNT_W + PCT_W;
    localparam int DC     = div_cycles(CNT_W);
    localparam int STEP_W = $clog2(DC + 1);

    logic [NUM_W-1:0]  acc;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  den_q;
    logic [CNT_W-1:0]  rem_nx;
    logic [CNT_W:0]    trial;
    logic [STEP_W-1:0] step;
    logic              qbit;

    // one restoring step: shift in next numerator bit, try subtract
    always_comb begin
        trial  = {rem, acc[NUM_W-1]};
        qbit   = (trial >= {1'b0, den_q});
        rem_nx = qbit ? CNT_W'(trial - {1'b0, den_q})
                      : trial[CNT_W-1:0];
    end

    assign quot = (acc > NUM_W'(PCT_MAX)) ? PCT_W'(PCT_MAX)
                                          : acc[PCT_W-1:0];

    // load operands on start, then iterate DC steps and flag done
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            step  <= '0;
            acc   <= '0;
            rem   <= '0;
            den_q <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy  <= 1'b1;
                step  <= STEP_W'(DC);
                acc   <= num;
                rem   <= '0;
                den_q <= den;
            end else if (busy) begin
                acc  <= {acc[NUM_W-2:0], qbit};
                rem  <= rem_nx;
                step <= step - STEP_W'(1);
                if (step == STEP_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// PWM receiver: measures period and high time,
// derives duty percent and flags stuck lines.
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    pwm_duty_decoder_if.slave bus
);
    localparam int NUM_W = CNT_W + PCT_W;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [PCT_W-1:0] PCT_FULL = PCT_W'(PCT_MAX);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] cap_period;
    logic [CNT_W-1:0] cap_high;
    logic             at_to;
    logic             arm;
    logic             cap;
    logic             to_hit;

    logic             div_start;
    logic             div_drop;
    logic             div_abort;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_num;
    logic [PCT_W-1:0] div_q;

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;
    logic [PCT_W-1:0] duty_q;
    logic             valid_q;
    logic             stuck_high_q;
    logic             stuck_low_q;
    logic             overrun_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // bring pwm_in into clk domain, keep one extra stage for edges
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
            s_d    <= s;
        end
    end

    assign at_to = (period_cnt == TO_VAL);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: arm on a rise, drop back on timeout or disable
    always_comb begin
        state_d = state_q;
        if (!bus.ena) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (rise) state_d = MEASURE;
                MEASURE: if (!rise && at_to) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // per-cycle events; a rise beats a simultaneous timeout
    always_comb begin
        arm    = 1'b0;
        cap    = 1'b0;
        to_hit = 1'b0;
        if (bus.ena) begin
            unique case (state_q)
                IDLE:    arm = rise;
                MEASURE: begin
                    cap    = rise;
                    to_hit = !rise && at_to;
                end
                default: ;
            endcase
        end
    end

    assign div_start = cap & ~div_busy;
    assign div_drop  = cap & div_busy;
    assign div_abort = ~bus.ena;
    assign div_num   = NUM_W'(high_cnt) * NUM_W'(PCT_MAX);

    // period/high counters, restarted at 1 on every rise
    always_ff @(posedge clk) begin
        if (rst || !bus.ena || to_hit) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else if (arm || cap) begin
            period_cnt <= CNT_W'(1);
            high_cnt   <= CNT_W'(1);
        end else if (state_q == MEASURE) begin
            period_cnt <= period_cnt + CNT_W'(1);
            high_cnt   <= high_cnt + CNT_W'(s);
        end
    end

    // hold the raw counts alongside the running division
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_period <= '0;
            cap_high   <= '0;
        end else if (div_start) begin
            cap_period <= period_cnt;
            cap_high   <= high_cnt;
        end
    end

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .abort (div_abort),
        .start (div_start),
        .num   (div_num),
        .den   (period_cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_q)
    );

    // publish results and flags; meas_valid rides with the update
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q     <= '0;
            high_q       <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (div_drop) begin
                overrun_q <= 1'b1;
            end
            if (arm) begin
                stuck_high_q <= 1'b0;
                stuck_low_q  <= 1'b0;
            end
            if (to_hit) begin
                period_q     <= TO_VAL;
                high_q       <= s ? TO_VAL : '0;
                duty_q       <= s ? PCT_FULL : '0;
                stuck_high_q <= s;
                stuck_low_q  <= ~s;
                valid_q      <= 1'b1;
            end else if (div_done && bus.ena) begin
                period_q <= cap_period;
                high_q   <= cap_high;
                duty_q   <= div_q;
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.period     = period_q;
    assign bus.high_time  = high_q;
    assign bus.duty_pct   = duty_q;
    assign bus.meas_valid = valid_q;
    assign bus.stuck_high = stuck_high_q;
    assign bus.stuck_low  = stuck_low_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
Receive-side counterpart of the tt_um PWM generator. It samples an external PWM waveform and measures the period and high time in clk cycles. It computes the integer duty cycle in percent and reports stuck-high and stuck-low lines. It is used on-chip for loop-back self-test of the generator and for closed-loop duty trimming.

Parameters:
CNT_W, 16, width of the period and high-time counters and outputs
SYNC_STAGES, 2, number of synchroniser flops on pwm_in (minimum 2)
TIMEOUT, 2**CNT_W-1, cycles without a rising edge before a stuck condition is declared

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ena  in  1  block enable
pwm_in  in  1  asynchronous PWM input
period  out  CNT_W  last measured period, in cycles
high_time  out  CNT_W  last measured high time, in cycles
duty_pct  out  7  floor(high_time*100/period), range 0..100
meas_valid  out  1  one-cycle pulse when period, high_time and duty_pct update together
stuck_high  out  1  pwm_in has been high for at least TIMEOUT cycles
stuck_low  out  1  pwm_in has been low for at least TIMEOUT cycles
overrun  out  1  sticky flag: a capture was dropped because the divider was busy

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 0.
- Input path: pwm_in passes through SYNC_STAGES flops to give s. One more flop gives s_d. rise = s & ~s_d. An input edge reaches rise SYNC_STAGES+1 cycles after the pin changes.
- FSM states: IDLE, MEASURE.
- IDLE:
  - On rise: go to MEASURE, set period_cnt=1 and high_cnt=1.
  - Clear stuck_high and stuck_low on this rise.
- MEASURE, on a rise cycle:
  - Capture period_cnt and high_cnt into the divider request.
  - Restart both counters at 1.
- MEASURE, on any other cycle:
  - period_cnt += 1.
  - high_cnt += s.
- Counting example: a waveform high 30 cycles per 100-cycle period gives period=100, high_time=30.
- Timeout: if period_cnt reaches TIMEOUT without a rise, go to IDLE.
  - If s=1: set stuck_high, drive duty_pct=100, high_time=period=TIMEOUT.
  - If s=0: set stuck_low, drive duty_pct=0, high_time=0, period=TIMEOUT.
  - Pulse meas_valid once, the cycle after the timeout.
  - Do not start the divider.
  - While in IDLE with a stuck flag set, no further meas_valid pulses are issued.
- Divider: sequential restoring divider of (high_cnt*100) by period_cnt.
  - Numerator width CNT_W+7; one quotient bit per cycle; DIV_CYCLES = CNT_W+7.
  - On completion, period, high_time and duty_pct update together, and meas_valid pulses on the next cycle.
  - Quotient is saturated to 100; cannot exceed it since high <= period.
- Busy collision: a capture that arrives while the divider is busy is dropped. overrun is set and cleared only by rst. The outputs keep the previous result. The minimum period measured without drops is DIV_CYCLES+1.
- First rise after reset or enable: only arms MEASURE; no output is produced. The first meas_valid follows the second rise.
- Counter width: counters never wrap, because the timeout fires at TIMEOUT <= 2**CNT_W-1.
- ena=0:
  - FSM forced to IDLE, counters cleared, any divider operation aborted with no meas_valid.
  - Outputs and flags hold their values; the synchroniser keeps running.
  - On re-enable, behaviour is as after a fresh arm.
- rst mid-measurement or mid-division: immediate return to the reset state, with no pulse.
- rise on the same cycle as the timeout: rise takes priority and is treated as a normal capture.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum (IDLE, MEASURE);
  - PCT_MAX=100 and PCT_W=7;
  - the default CNT_W;
  - the DIV_CYCLES function.
- One natural sub-module: pwm_duty_div, the sequential divider with start/busy/done and quotient saturation, instantiated once.
- Synchroniser and edge detection stay inline.

Test Plan:
- Steady 30% duty: pwm_in high 30 / low 70 for 5 periods, CNT_W=16 -> first meas_valid after the 2nd rise plus 24 cycles; period=100, high_time=30, duty_pct=30; exactly one pulse per period thereafter.
- Duty steps like the generator: 100-cycle periods at 30%, 40%, 50%, then 40%, 30%, 20% -> duty_pct sequence 30, 40, 50, 40, 30, 20; each new value appears one period after the waveform changes.
- Stuck low: pwm_in held 0 with TIMEOUT=200 -> stuck_low=1, duty_pct=0, high_time=0, period=200, a single meas_valid; next rise clears stuck_low, and valid measurements resume after one more period.
- Stuck high: pwm_in held 1 with TIMEOUT=200 -> stuck_high=1, duty_pct=100, high_time=period=200, a single meas_valid.
- Overrun: 10-cycle period (below DIV_CYCLES) -> overrun=1 and sticky; results update only when the divider is free; period=10, high_time=3, duty_pct=30 for a 3/7 waveform.
- Reset/enable: assert rst mid-division -> no meas_valid and all outputs 0; deassert ena mid-period -> outputs hold, and after re-enable the first meas_valid follows the 2nd rise.
